// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master controller: RESP codes,
// FSM state encoding and default bus widths.
package axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_master_ctrl.sv
// Runs one AXI4-Lite read or write per client command and hands back a
// single response carrying read data and the slave's RESP code.
module axi4_lite_master_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int         ADDR_W = AXI_ADDR_W,
  parameter int         DATA_W = AXI_DATA_W,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done, w_done;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic                cmd_accept;

  assign cmd_accept = cmd_valid && cmd_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // AW and W finish independently; a channel already done counts as finished.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_accept) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = RSP;
      RD_REQ:  if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !areset;
    awvalid   = (state == WR_REQ) && !aw_done;
    wvalid    = (state == WR_REQ) && !w_done;
    bready    = (state == WR_RESP);
    arvalid   = (state == RD_REQ);
    rready    = (state == RD_DATA);
    rsp_valid = (state == RSP);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      // Writes report zero data so a stale read value never leaks out.
      if (bready && bvalid) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= bresp;
      end
      if (rready && rvalid) begin
        rsp_rdata_q <= rdata;
        rsp_resp_q  <= rresp;
      end
    end
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = PROT;
  assign arprot    = PROT;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule
